// File: rtl/rx_frame_buffer_if.sv
// Frame handshake bundle between the UART receiver, the receive buffer and its consumer.
// master drives received frames and OutReady; slave (the buffer) presents the head frame.
interface rx_frame_buffer_if;
  logic [7:0] DataIn;
  logic [2:0] ErrorIn;
  logic       FrameValid;
  logic       OutReady;
  logic       OutValid;
  logic [7:0] OutData;
  logic [2:0] OutError;

  modport master (
    output DataIn,
    output ErrorIn,
    output FrameValid,
    output OutReady,
    input  OutValid,
    input  OutData,
    input  OutError
  );

  modport slave (
    input  DataIn,
    input  ErrorIn,
    input  FrameValid,
    input  OutReady,
    output OutValid,
    output OutData,
    output OutError
  );
endinterface

// File: rtl/rx_frame_buffer.sv
// Receive-side show-ahead FIFO storing {error flags, data byte} frames from the UART receiver,
// with sticky overrun detection and optional discarding and counting of errored frames.
module rx_frame_buffer #(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter bit DROP_ERR = 1'b0
) (
  input  logic              Clock,
  input  logic              Reset,
  rx_frame_buffer_if.slave  frameIf,
  input  logic              ClearStatus,
  output logic [ADDR_W:0]   Count,
  output logic              Full,
  output logic              Empty,
  output logic              Overrun,
  output logic [7:0]        ErrCount
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [7:0]      ERR_MAX    = 8'hFF;

  logic [10:0]       mem [DEPTH];

  logic [ADDR_W-1:0] wrPtrReg, wrPtrNext;
  logic [ADDR_W-1:0] rdPtrReg, rdPtrNext;
  logic [ADDR_W:0]   countReg, countNext;
  logic              overrunReg, overrunNext;
  logic [7:0]        errCountReg, errCountNext;

  logic              frameHasError;
  logic              errDrop;
  logic              pushReq;
  logic              popEn;
  logic              wrEn;
  logic              overrunEvent;
  logic              isFull;
  logic              isEmpty;
  logic [10:0]       headEntry;

  assign isFull  = (countReg == FULL_COUNT);
  assign isEmpty = (countReg == '0);

  // Errored frames are only filtered when DROP_ERR is set; otherwise they are stored with flags.
  assign frameHasError = (frameIf.ErrorIn != 3'b000);
  assign errDrop       = DROP_ERR && frameIf.FrameValid && frameHasError;
  assign pushReq       = frameIf.FrameValid && !errDrop;

  // A pop needs a visible head, so OutReady against an empty buffer does nothing.
  assign popEn         = !isEmpty && frameIf.OutReady;
  assign wrEn          = pushReq && (!isFull || popEn);
  assign overrunEvent  = pushReq && isFull && !popEn;

  always_comb begin
    wrPtrNext    = wrPtrReg;
    rdPtrNext    = rdPtrReg;
    countNext    = countReg;
    overrunNext  = overrunReg;
    errCountNext = errCountReg;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (wrEn) begin
      wrPtrNext = wrPtrReg + 1'b1;
    end
    if (popEn) begin
      rdPtrNext = rdPtrReg + 1'b1;
    end

    unique case ({wrEn, popEn})
      2'b10:   countNext = countReg + 1'b1;
      2'b01:   countNext = countReg - 1'b1;
      default: countNext = countReg;
    endcase

    // A fresh event in the same cycle as ClearStatus takes precedence over the clear.
    if (overrunEvent) begin
      overrunNext = 1'b1;
    end else if (ClearStatus) begin
      overrunNext = 1'b0;
    end

    if (errDrop) begin
      if (ClearStatus) begin
        errCountNext = 8'd1;
      end else if (errCountReg != ERR_MAX) begin
        errCountNext = errCountReg + 8'd1;
      end
    end else if (ClearStatus) begin
      errCountNext = 8'd0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrPtrReg    <= '0;
      rdPtrReg    <= '0;
      countReg    <= '0;
      overrunReg  <= 1'b0;
      errCountReg <= 8'd0;
    end else begin
      wrPtrReg    <= wrPtrNext;
      rdPtrReg    <= rdPtrNext;
      countReg    <= countNext;
      overrunReg  <= overrunNext;
      errCountReg <= errCountNext;
    end
  end

  // Storage is deliberately not reset; a write coincident with reset is discarded.
  always_ff @(posedge Clock) begin
    if (wrEn && !Reset) begin
      mem[wrPtrReg] <= {frameIf.ErrorIn, frameIf.DataIn};
    end
  end

  // Head entry is read asynchronously so the oldest frame is visible the cycle after it lands.
  assign headEntry = mem[rdPtrReg];

  always_comb begin
    frameIf.OutValid = !isEmpty;
    frameIf.OutData  = 8'h00;
    frameIf.OutError = 3'b000;
    if (!isEmpty) begin
      frameIf.OutData  = headEntry[7:0];
      frameIf.OutError = headEntry[10:8];
    end
  end

  assign Count    = countReg;
  assign Full     = isFull;
  assign Empty    = isEmpty;
  assign Overrun  = overrunReg;
  assign ErrCount = errCountReg;

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Bench for rx_frame_buffer: one instance storing errored frames, one discarding them, both
// driven identically and compared every cycle against a circular-buffer reference model.
module tb_rx_frame_buffer;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic clearStatus;

  rx_frame_buffer_if fIf0 ();
  rx_frame_buffer_if fIf1 ();

  logic [ADDR_W:0] count0, count1;
  logic full0, full1, empty0, empty1, overrun0, overrun1;
  logic [7:0] errCount0, errCount1;

  rx_frame_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DROP_ERR(1'b0)) dutKeep (
    .Clock(clk), .Reset(rst), .frameIf(fIf0), .ClearStatus(clearStatus),
    .Count(count0), .Full(full0), .Empty(empty0), .Overrun(overrun0), .ErrCount(errCount0)
  );

  rx_frame_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DROP_ERR(1'b1)) dutDrop (
    .Clock(clk), .Reset(rst), .frameIf(fIf1), .ClearStatus(clearStatus),
    .Count(count1), .Full(full1), .Empty(empty1), .Overrun(overrun1), .ErrCount(errCount1)
  );

  int testsRun  = 0;
  int testsFail = 0;

  // Reference model: circular buffer with head index and occupancy per instance.
  logic [10:0] mMem [2][DEPTH];
  int          mHead [2];
  int          mCnt  [2];
  bit          mOv   [2];
  int          mEc   [2];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFail++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic modelStep(input int k, input bit fv, input logic [7:0] d, input logic [2:0] e,
                           input bit rdy, input bit clr, input bit rs);
    bit popv, errEv, push, ovEv, pushOk;
    if (rs) begin
      mHead[k] = 0; mCnt[k] = 0; mOv[k] = 0; mEc[k] = 0;
      return;
    end
    popv   = (mCnt[k] > 0) && rdy;
    errEv  = (k == 1) && fv && (e != 3'b000);
    push   = fv && !errEv;
    ovEv   = push && (mCnt[k] == DEPTH) && !popv;
    pushOk = push && ((mCnt[k] < DEPTH) || popv);
    if (popv) begin
      $display("[TB] u%0d pop data=%02h err=%03b", k, mMem[k][mHead[k]][7:0], mMem[k][mHead[k]][10:8]);
      mHead[k] = (mHead[k] + 1) % DEPTH;
      mCnt[k]--;
    end
    if (pushOk) begin
      mMem[k][(mHead[k] + mCnt[k]) % DEPTH] = {e, d};
      mCnt[k]++;
    end
    if (ovEv) mOv[k] = 1;
    else if (clr) mOv[k] = 0;
    if (errEv) mEc[k] = clr ? 1 : ((mEc[k] < 255) ? mEc[k] + 1 : 255);
    else if (clr) mEc[k] = 0;
  endtask

  task automatic checkInst(input int k, input logic ov, input logic [7:0] od, input logic [2:0] oe,
                           input logic [ADDR_W:0] cnt, input logic fl, input logic em,
                           input logic orun, input logic [7:0] ec);
    bit nonEmpty;
    nonEmpty = mCnt[k] > 0;
    checkVal($sformatf("u%0d_valid", k), ov, nonEmpty);
    checkVal($sformatf("u%0d_data", k), od, nonEmpty ? mMem[k][mHead[k]][7:0] : 8'h00);
    checkVal($sformatf("u%0d_err", k), oe, nonEmpty ? mMem[k][mHead[k]][10:8] : 3'b000);
    checkVal($sformatf("u%0d_count", k), cnt, mCnt[k]);
    checkVal($sformatf("u%0d_full", k), fl, mCnt[k] == DEPTH);
    checkVal($sformatf("u%0d_empty", k), em, mCnt[k] == 0);
    checkVal($sformatf("u%0d_overrun", k), orun, mOv[k]);
    checkVal($sformatf("u%0d_errcount", k), ec, mEc[k]);
  endtask

  task automatic cycle(input bit fv, input logic [7:0] d, input logic [2:0] e,
                       input bit rdy, input bit clr, input bit rs);
    fIf0.FrameValid = fv;  fIf1.FrameValid = fv;
    fIf0.DataIn     = d;   fIf1.DataIn     = d;
    fIf0.ErrorIn    = e;   fIf1.ErrorIn    = e;
    fIf0.OutReady   = rdy; fIf1.OutReady   = rdy;
    clearStatus     = clr;
    rst             = rs;
    @(posedge clk);
    modelStep(0, fv, d, e, rdy, clr, rs);
    modelStep(1, fv, d, e, rdy, clr, rs);
    #1;
    checkInst(0, fIf0.OutValid, fIf0.OutData, fIf0.OutError, count0, full0, empty0, overrun0, errCount0);
    checkInst(1, fIf1.OutValid, fIf1.OutData, fIf1.OutError, count1, full1, empty1, overrun1, errCount1);
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] e);
    cycle(1'b1, d, e, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic popOnly();
    cycle(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    cycle(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    doReset();
    checkVal("reset_empty", empty0, 1'b1);
    checkVal("reset_valid", fIf0.OutValid, 1'b0);

    // Basic ordering with flags stored.
    push(8'h41, 3'b000);
    push(8'h42, 3'b001);
    push(8'h43, 3'b100);
    checkVal("basic_count", count0, 3);
    checkVal("basic_head", fIf0.OutData, 8'h41);
    checkVal("basic_drop_count", count1, 1);
    checkVal("basic_drop_errcnt", errCount1, 2);
    for (int i = 0; i < 3; i++) popOnly();
    checkVal("basic_drained", empty0, 1'b1);
    checkVal("basic_masked", fIf0.OutData, 8'h00);

    // Fill, overrun, drain, clear.
    for (int i = 0; i < DEPTH; i++) push(8'(i), 3'b000);
    checkVal("fill_full", full0, 1'b1);
    push(8'hAA, 3'b000);
    checkVal("ovr_flag", overrun0, 1'b1);
    checkVal("ovr_count", count0, DEPTH);
    for (int i = 0; i < DEPTH; i++) popOnly();
    cycle(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0);
    checkVal("ovr_cleared", overrun0, 1'b0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) push(8'(8'h60 + i), 3'b000);
    cycle(1'b1, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0);
    checkVal("fullpp_count", count0, DEPTH);
    checkVal("fullpp_overrun", overrun0, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) popOnly();
    checkVal("fullpp_last", fIf0.OutData, 8'h55);
    popOnly();

    // Interleaved push/pop for pointer wrap.
    for (int i = 0; i < 20; i++) begin
      push(8'(8'h10 + i), 3'b000);
      checkVal("wrap_head", fIf0.OutData, 8'(8'h10 + i));
      popOnly();
      checkVal("wrap_count", count0, 0);
    end

    // Error filtering and clear precedence.
    push(8'h11, 3'b000);
    push(8'h22, 3'b010);
    push(8'h33, 3'b001);
    push(8'h44, 3'b000);
    checkVal("drop_count", count1, 2);
    checkVal("drop_errcnt", errCount1, 2);
    for (int i = 0; i < 4; i++) popOnly();
    cycle(1'b1, 8'h66, 3'b010, 1'b0, 1'b1, 1'b0);
    checkVal("drop_clr_evt", errCount1, 1);
    checkVal("drop_no_ovr", overrun1, 1'b0);

    // ErrCount saturation.
    for (int i = 0; i < 260; i++) cycle(1'b1, 8'h99, 3'b100, 1'b0, 1'b0, 1'b0);
    checkVal("sat_errcnt", errCount1, 255);

    // Reset mid-stream.
    doReset();
    for (int i = 0; i < 5; i++) push(8'(8'h30 + i), 3'b000);
    checkVal("mid_count", count0, 5);
    cycle(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b1);
    checkVal("mid_reset_count", count0, 0);
    checkVal("mid_reset_valid", fIf0.OutValid, 1'b0);
    push(8'h7E, 3'b000);
    checkVal("mid_readback", fIf0.OutData, 8'h7E);
    popOnly();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit fv, rdy, clr, rs;
      logic [2:0] e;
      fv  = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 15) == 0);
      rs  = ($urandom_range(0, 127) == 0);
      e   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      cycle(fv, 8'($urandom), e, rdy, clr, rs);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end
endmodule

// File: doc/rx_frame_buffer.md
Name: rx_frame_buffer

Overview:
- Receive-side FIFO that sits directly downstream of the UART receiver top.
- Captures each completed 8-bit data byte together with its 3-bit error flags (parity/start/stop) on a one-cycle frame-valid strobe.
- Presents the oldest frame to the consumer (CPU/bus side) over a valid/ready handshake.
- Reports overrun and optionally filters out errored frames, counting them.

Parameters:
- DEPTH, 8, number of frame entries; power of two, >= 2.
- ADDR_W, 3, log2(DEPTH).
- DROP_ERR, 0, 1 = frames with any ErrorIn bit set are discarded (not stored) and counted; 0 = stored with their flags.

Ports:
- Clock  input  1  system clock, all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- DataIn  input  8  received data byte from receiver.
- ErrorIn  input  3  [0] parity, [1] start, [2] stop error, aligned with DataIn.
- FrameValid  input  1  one-cycle strobe: DataIn/ErrorIn hold a completed frame.
- OutReady  input  1  consumer accepts the head frame this cycle.
- ClearStatus  input  1  clears Overrun and ErrCount.
- OutValid  output  1  head frame available.
- OutData  output  8  head frame data byte.
- OutError  output  3  head frame error flags.
- Count  output  ADDR_W+1  number of stored frames, 0..DEPTH.
- Full  output  1  Count == DEPTH.
- Empty  output  1  Count == 0.
- Overrun  output  1  sticky: a frame arrived while full.
- ErrCount  output  8  saturating count of discarded errored frames (DROP_ERR=1 only; otherwise 0).

Behaviour:
- Reset (Clock edge with Reset=1): wr/rd pointers = 0, Count = 0, Empty = 1, Full = 0, OutValid = 0, OutData = 0, OutError = 0, Overrun = 0, ErrCount = 0. Storage array is not reset.
- Reset overrides every other input in the same cycle, including mid-stream; any stored frames are lost.
- Entry format: 11 bits, {ErrorIn, DataIn}.
- Push request: FrameValid=1, and, when DROP_ERR=1, ErrorIn==3'b000.
- Pop: OutValid & OutReady.
- Write accepted: push request & (!Full | pop same cycle). Entry goes to mem[wr_ptr]; wr_ptr increments, wrapping DEPTH-1 -> 0.
- Pop behaviour: rd_ptr increments with the same wrap.
- Count: +1 on accepted write only, -1 on pop only, unchanged when both occur.
- Show-ahead output: OutValid = !Empty, and OutData/OutError = mem[rd_ptr] when !Empty.
- When Empty, OutData = 0 and OutError = 0 (masked, combinational from registered state).
- Latency: a frame written at edge N has OutValid=1 from edge N onward when the FIFO was empty, i.e. it is visible in the following cycle. No fall-through in the same cycle.
- Empty + FrameValid + OutReady in the same cycle: the write is accepted and the pop is ignored, because OutValid=0.
- Full + FrameValid + OutReady: write accepted, pop performed, Count stays DEPTH, no overrun.
- Full + FrameValid without a pop: frame dropped, Overrun <= 1, storage and pointers unchanged.
- DROP_ERR=1 and FrameValid with ErrorIn != 0: frame not stored regardless of fullness; ErrCount <= ErrCount+1, saturating at 255; Overrun not set.
- ClearStatus: Overrun <= 0 and ErrCount <= 0. If a new overrun or errored-frame event occurs in the same cycle, the event wins: Overrun=1, ErrCount=1.
- OutReady while Empty: no effect.
- FrameValid held high multiple cycles: each cycle is treated as a separate frame. The upstream block guarantees single-cycle strobes.

Test Plan:
- Reset, then push 0x41/err 000, 0x42/err 001, 0x43/err 100 with OutReady=0 -> Count=3, OutValid=1, OutData=0x41/OutError=000. Then OutReady=1 for 3 cycles -> pops 0x41, 0x42 (err 001), 0x43 (err 100) in order, then Empty=1, OutData=0.
- DEPTH=8: push 0x00..0x07 -> Full=1, Count=8. Push 0xAA -> Overrun=1, Count=8, 0xAA never read. Drain -> 0x00..0x07. ClearStatus -> Overrun=0.
- Full with FrameValid(0x55) and OutReady in the same cycle -> Count stays 8, Overrun=0. After draining, the last frame read is 0x55.
- Wrap-around: 20 interleaved push/pop pairs of 0x10..0x23 -> output order preserved, pointers wrap, Count never exceeds 1.
- DROP_ERR=1: push 0x11/000, 0x22/010, 0x33/001, 0x44/000 -> only 0x11 and 0x44 stored, ErrCount=2. ClearStatus coincident with an errored push -> ErrCount=1.
- Reset asserted with Count=5 and OutReady=1 -> next cycle Count=0, Empty=1, OutValid=0. A subsequent push of 0x7E reads back 0x7E.
